mem_access_unit: RTL

Load/store stage directly downstream of the integer ALU: takes the ALU-computed effective address together with the memory opcode, store data and destination register, and runs one data-memory transaction at a time over a request/grant/response bus. It handles byte-lane steering, byte enables, load sign/zero extension, misalignment detection and a response timeout, and hands load results to write-back. While an access is in flight it holds off the execute stage.

---
 rtl/mem_access_unit.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit running one data-memory access at a time
//
// Purpose: takes an effective address, memory opcode, store data and
// destination register from execute, runs a single transaction over a
// request/grant/response bus and returns extended load data to write-back.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   ex_*                   execute-side op handshake (ex_ready high only in IDLE)
//   dmem_req/we/addr/be/wdata   registered bus request, held until dmem_gnt
//   dmem_gnt, dmem_rvalid, dmem_rdata   bus grant and read response
//   wb_valid/wb_rd/wb_data load write-back (one-cycle pulse)
//   st_done                store granted (one-cycle pulse)
//   err/err_code           01 misaligned, 10 illegal funct3, 11 timeout
`ifndef instWidth
`define instWidth 32
`endif

module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ex_valid,
  output logic                    ex_ready,
  input  logic                    ex_is_store,
  input  logic [2:0]              ex_funct3,
  input  logic [`instWidth-1:0]   ex_addr,
  input  logic [`instWidth-1:0]   ex_wdata,
  input  logic [4:0]              ex_rd,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [`instWidth-1:0]   dmem_addr,
  output logic [3:0]              dmem_be,
  output logic [`instWidth-1:0]   dmem_wdata,
  input  logic                    dmem_gnt,
  input  logic                    dmem_rvalid,
  input  logic [`instWidth-1:0]   dmem_rdata,
  output logic                    wb_valid,
  output logic [4:0]              wb_rd,
  output logic [`instWidth-1:0]   wb_data,
  output logic                    st_done,
  output logic                    err,
  output logic [1:0]              err_code
);

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP,
    S_FAULT
  } state_t;

  state_t      r_state;
  logic        r_is_store;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [4:0]  r_rd;
  logic [7:0]  r_cnt;

  logic                  w_illegal;
  logic                  w_misal;
  logic [3:0]            w_be;
  logic [`instWidth-1:0] w_wdata;
  logic [`instWidth-1:0] w_shift;
  logic [`instWidth-1:0] w_ld;

  assign ex_ready = (r_state == S_IDLE);

  // Loads accept 000/001/010/100/101, stores only 000/001/010.
  always_comb begin
    w_illegal = 1'b0;
    if (ex_is_store)
      w_illegal = ex_funct3[2] | (ex_funct3[1:0] == 2'b11);
    else
      w_illegal = (ex_funct3[1:0] == 2'b11) | (ex_funct3[2] & ex_funct3[1]);
  end

  // funct3[1:0] encodes access width for every legal code.
  always_comb begin
    w_misal = 1'b0;
    case (ex_funct3[1:0])
      2'b01:   w_misal = ex_addr[0];
      2'b10:   w_misal = (ex_addr[1:0] != 2'b00);
      default: w_misal = 1'b0;
    endcase
  end

  // Sub-word stores replicate the data so the selected lane always carries it.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = ex_wdata;
    case (ex_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << ex_addr[1:0];
        w_wdata = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << ex_addr[1:0];
        w_wdata = {2{ex_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = ex_wdata;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend.
  assign w_shift = dmem_rdata >> {r_addr_lo, 3'b000};

  always_comb begin
    w_ld = w_shift;
    case (r_funct3)
      3'b000:  w_ld = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_ld = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_ld = {24'd0, w_shift[7:0]};
      3'b101:  w_ld = {16'd0, w_shift[15:0]};
      default: w_ld = w_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_is_store <= 1'b0;
      r_funct3   <= 3'd0;
      r_addr_lo  <= 2'd0;
      r_rd       <= 5'd0;
      r_cnt      <= 8'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= 4'd0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= '0;
      st_done    <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      // Status outputs are single-cycle pulses.
      wb_valid <= 1'b0;
      st_done  <= 1'b0;
      err      <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (ex_valid) begin
            r_is_store <= ex_is_store;
            r_funct3   <= ex_funct3;
            r_addr_lo  <= ex_addr[1:0];
            r_rd       <= ex_rd;
            if (w_illegal) begin
              err      <= 1'b1;
              err_code <= 2'b10;
              r_state  <= S_FAULT;
            end else if (w_misal) begin
              err      <= 1'b1;
              err_code <= 2'b01;
              r_state  <= S_FAULT;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= ex_is_store;
              dmem_addr  <= {ex_addr[`instWidth-1:2], 2'b00};
              dmem_be    <= w_be;
              dmem_wdata <= w_wdata;
              r_state    <= S_REQ;
            end
          end
        end

        S_REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (r_is_store) begin
              st_done <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_cnt   <= 8'd0;
              r_state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (dmem_rvalid) begin
            wb_data  <= w_ld;
            wb_rd    <= r_rd;
            wb_valid <= 1'b1;
            r_state  <= S_RESP;
          end else if (r_cnt == LP_CNT_LAST) begin
            err      <= 1'b1;
            err_code <= 2'b11;
            r_state  <= S_FAULT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_RESP:  r_state <= S_IDLE;
        S_FAULT: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
